spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_clkgen.sv | 37 +++
 rtl/spi_master.sv | 190 +++++++++++++++++++
 tb/tb_spi_master.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared FSM encoding, mode constants and helpers for the SPI master.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SCK_LO = 3'd2,
        ST_SCK_HI = 3'd3,
        ST_DONE   = 3'd4
    } spi_state_e;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_DUAL   = 1'b1;
    localparam logic DIR_READ    = 1'b0;
    localparam logic DIR_WRITE   = 1'b1;

    localparam int unsigned EDGE_W = 4;

    // Per-byte options captured when a transfer is accepted.
    typedef struct packed {
        logic dual;
        logic hold;
    } xfer_cfg_t;

    // Rising SCK edges needed to move one byte.
    function automatic logic [EDGE_W-1:0] edges_per_byte(input logic dual);
        return (dual == MODE_DUAL) ? EDGE_W'(4) : EDGE_W'(8);
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCK half-period timer: reloads div on load_i, then ticks in the last cycle of every div+1 window.
module spi_clkgen #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic             tick_q;

    // tick_q mirrors (cnt_q == 0) so the FSM sees the phase end without extra decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (load_i) begin
            div_q  <= div_i;
            cnt_q  <= div_i;
            tick_q <= (div_i == '0);
        end else if (tick_q) begin
            cnt_q  <= div_q;
            tick_q <= (div_q == '0);
        end else begin
            cnt_q  <= cnt_q - DIV_W'(1);
            tick_q <= (cnt_q == DIV_W'(1));
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master moving one byte per start, single or dual I/O, with held chip-select support.
module spi_master
    import spi_pkg::*;
#(
    parameter  int unsigned NUM_CS = 2,
    parameter  int unsigned DIV_W  = 8,
    localparam int unsigned CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              CLK1,
    input  logic              RST_N,
    input  logic              start,
    input  logic              dual,
    input  logic              dual_dir,
    input  logic [7:0]        wr_data,
    input  logic [DIV_W-1:0]  div,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cs_hold,
    input  logic              cs_release,
    output logic [7:0]        rd_data,
    output logic              busy,
    output logic              done,
    output logic              SPI_SCK,
    output logic [NUM_CS-1:0] SPI_SS,
    output logic              IO0_O,
    output logic              IO0_OE,
    input  logic              IO0_I,
    output logic              IO1_O,
    output logic              IO1_OE,
    input  logic              IO1_I
);

    spi_state_e        state_q;
    xfer_cfg_t         cfg_q;
    logic [7:0]        tx_q;
    logic [7:0]        rx_q;
    logic [7:0]        rd_q;
    logic [EDGE_W-1:0] edges_q;
    logic [CS_W-1:0]   cs_q;
    logic              held_q;
    logic [NUM_CS-1:0] ss_q;
    logic              sck_q;
    logic              busy_q;
    logic              done_q;
    logic              io0_q;
    logic              io1_q;
    logic              oe0_q;
    logic              oe1_q;

    logic              tick;
    logic              load_c;
    logic [CS_W-1:0]   cs_idx_c;
    logic [7:0]        rx_next_c;

    assign load_c   = (state_q == ST_IDLE) && start;
    assign cs_idx_c = held_q ? cs_q : cs_sel;

    // Dual mode takes the higher bit from IO1.
    always_comb begin
        rx_next_c = {rx_q[6:0], IO1_I};
        if (cfg_q.dual == MODE_DUAL) begin
            rx_next_c = {rx_q[5:0], IO1_I, IO0_I};
        end
    end

    spi_clkgen #(
        .DIV_W (DIV_W)
    ) u_clkgen (
        .clk    (CLK1),
        .rst_n  (RST_N),
        .load_i (load_c),
        .div_i  (div),
        .tick_o (tick)
    );

    always_ff @(posedge CLK1 or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rd_q    <= '0;
            edges_q <= '0;
            cs_q    <= '0;
            held_q  <= 1'b0;
            ss_q    <= '1;
            sck_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            io0_q   <= 1'b0;
            io1_q   <= 1'b0;
            oe0_q   <= 1'b0;
            oe1_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_SETUP;
                        busy_q     <= 1'b1;
                        cfg_q.dual <= dual;
                        cfg_q.hold <= cs_hold;
                        cs_q       <= cs_idx_c;
                        ss_q       <= ~(NUM_CS'(1) << cs_idx_c);
                        rx_q       <= '0;
                        edges_q    <= '0;
                        // First bit(s) are presented for the whole setup phase.
                        if (dual == MODE_DUAL) begin
                            io1_q <= wr_data[7];
                            io0_q <= wr_data[6];
                            tx_q  <= {wr_data[5:0], 2'b00};
                            oe0_q <= (dual_dir == DIR_WRITE);
                            oe1_q <= (dual_dir == DIR_WRITE);
                        end else begin
                            io1_q <= 1'b0;
                            io0_q <= wr_data[7];
                            tx_q  <= {wr_data[6:0], 1'b0};
                            oe0_q <= 1'b1;
                            oe1_q <= 1'b0;
                        end
                    end else if (cs_release) begin
                        ss_q   <= '1;
                        held_q <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        state_q <= ST_SCK_HI;
                        sck_q   <= 1'b1;
                        rx_q    <= rx_next_c;
                        edges_q <= edges_q + EDGE_W'(1);
                    end
                end
                ST_SCK_HI: begin
                    if (tick) begin
                        state_q <= ST_SCK_LO;
                        sck_q   <= 1'b0;
                        if (cfg_q.dual == MODE_DUAL) begin
                            io1_q <= tx_q[7];
                            io0_q <= tx_q[6];
                            tx_q  <= {tx_q[5:0], 2'b00};
                        end else begin
                            io0_q <= tx_q[7];
                            tx_q  <= {tx_q[6:0], 1'b0};
                        end
                    end
                end
                ST_SCK_LO: begin
                    if (tick) begin
                        if (edges_q == edges_per_byte(cfg_q.dual)) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            rd_q    <= rx_q;
                            oe0_q   <= 1'b0;
                            oe1_q   <= 1'b0;
                            io0_q   <= 1'b0;
                            io1_q   <= 1'b0;
                            held_q  <= cfg_q.hold;
                            if (!cfg_q.hold) begin
                                ss_q <= '1;
                            end
                        end else begin
                            state_q <= ST_SCK_HI;
                            sck_q   <= 1'b1;
                            rx_q    <= rx_next_c;
                            edges_q <= edges_q + EDGE_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_data = rd_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign SPI_SCK = sck_q;
    assign SPI_SS  = ss_q;
    assign IO0_O   = io0_q;
    assign IO0_OE  = oe0_q;
    assign IO1_O   = io1_q;
    assign IO1_OE  = oe1_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback and dual-read slave, hold/release, abort and divider cases.
module tb_spi_master;

    localparam int unsigned NUM_CS = 2;
    localparam int unsigned DIV_W  = 8;

    logic             CLK1 = 1'b0;
    logic             RST_N = 1'b0;
    logic             start = 1'b0;
    logic             dual = 1'b0;
    logic             dual_dir = 1'b0;
    logic [7:0]       wr_data = '0;
    logic [DIV_W-1:0] div = '0;
    logic [0:0]       cs_sel = '0;
    logic             cs_hold = 1'b0;
    logic             cs_release = 1'b0;
    logic [7:0]       rd_data;
    logic             busy;
    logic             done;
    logic             SPI_SCK;
    logic [1:0]       SPI_SS;
    logic             IO0_O, IO0_OE, IO0_I;
    logic             IO1_O, IO1_OE, IO1_I;

    int total  = 0;
    int passed = 0;

    // Slave model: loopback of IO0_O, or a dual-read byte advanced on each SCK fall.
    logic       loopback = 1'b1;
    logic [7:0] slave_byte = '0;
    int         falls = 0;
    int         falls_base = 0;
    logic [7:0] slave_sh;

    always @(negedge SPI_SCK) falls++;

    always_comb begin
        slave_sh = slave_byte << (2 * (falls - falls_base));
        if (loopback) begin
            IO1_I = IO0_O;
            IO0_I = 1'b0;
        end else begin
            IO1_I = slave_sh[7];
            IO0_I = slave_sh[6];
        end
    end

    // Activity counters sampled on the falling clock edge; the bench only reads differences.
    int busy_cyc = 0, sck_rises = 0, done_cnt = 0, ss0_low = 0, ss1_high = 0, multi_low = 0;
    int hi_run = 0, last_hi = 0;
    logic sck_prev = 1'b0;

    always @(negedge CLK1) begin
        if (busy) busy_cyc++;
        if (done) done_cnt++;
        if (SPI_SCK && !sck_prev) sck_rises++;
        sck_prev = SPI_SCK;
        if (!SPI_SS[0]) ss0_low++;
        if (SPI_SS[1]) ss1_high++;
        if (SPI_SS == 2'b00) multi_low++;
        if (SPI_SCK) hi_run++;
        else begin
            if (hi_run != 0) last_hi = hi_run;
            hi_run = 0;
        end
    end

    always #5 CLK1 = ~CLK1;

    spi_master #(
        .NUM_CS (NUM_CS),
        .DIV_W  (DIV_W)
    ) dut (
        .CLK1       (CLK1),
        .RST_N      (RST_N),
        .start      (start),
        .dual       (dual),
        .dual_dir   (dual_dir),
        .wr_data    (wr_data),
        .div        (div),
        .cs_sel     (cs_sel),
        .cs_hold    (cs_hold),
        .cs_release (cs_release),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .SPI_SCK    (SPI_SCK),
        .SPI_SS     (SPI_SS),
        .IO0_O      (IO0_O),
        .IO0_OE     (IO0_OE),
        .IO0_I      (IO0_I),
        .IO1_O      (IO1_O),
        .IO1_OE     (IO1_OE),
        .IO1_I      (IO1_I)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK1);
        #1;
    endtask

    // Drive one start pulse; returns one cycle into the setup phase.
    task automatic launch(input logic d, input logic dir, input logic [7:0] wd,
                          input logic [DIV_W-1:0] dv, input logic [0:0] cs, input logic hold);
        dual     = d;
        dual_dir = dir;
        wr_data  = wd;
        div      = dv;
        cs_sel   = cs;
        cs_hold  = hold;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK1);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int b_busy, b_sck, b_done, b_ss0, b_ss1, rises;
        logic prev;

        // Reset values while RST_N is held low.
        repeat (2) @(negedge CLK1);
        check("rst_sck", SPI_SCK, 1'b0);
        check("rst_ss", SPI_SS, 2'b11);
        check("rst_oe", {IO1_OE, IO0_OE}, 2'b00);
        check("rst_io", {IO1_O, IO0_O}, 2'b00);
        check("rst_busy_done", {busy, done}, 2'b00);
        check("rst_rd", rd_data, 8'h00);
        RST_N = 1'b1;
        step();

        // Single, div=0, 0xA5 loopback.
        loopback = 1'b1;
        b_busy = busy_cyc; b_sck = sck_rises; b_done = done_cnt;
        launch(1'b0, 1'b0, 8'hA5, 8'd0, 1'b0, 1'b0);
        check("a5_ss_low", SPI_SS, 2'b10);
        check("a5_oe", {IO1_OE, IO0_OE}, 2'b01);
        check("a5_first_bit", IO0_O, 1'b1);
        wait_done(100, ok);
        check("a5_done_seen", ok, 1'b1);
        check("a5_rd", rd_data, 8'hA5);
        check("a5_ss_high", SPI_SS, 2'b11);
        check("a5_busy_low", busy, 1'b0);
        step();
        check("a5_done_1cyc", done, 1'b0);
        check("a5_busy_cyc", busy_cyc - b_busy, 17);
        check("a5_sck_pulses", sck_rises - b_sck, 8);
        check("a5_done_cnt", done_cnt - b_done, 1);

        // Dual read, div=3, slave returns 0x3C.
        loopback = 1'b0; slave_byte = 8'h3C; falls_base = falls;
        b_busy = busy_cyc; b_sck = sck_rises;
        launch(1'b1, 1'b0, 8'h00, 8'd3, 1'b0, 1'b0);
        check("dr_oe", {IO1_OE, IO0_OE}, 2'b00);
        wait_done(200, ok);
        check("dr_done_seen", ok, 1'b1);
        check("dr_rd", rd_data, 8'h3C);
        step();
        check("dr_busy_cyc", busy_cyc - b_busy, 36);
        check("dr_sck_pulses", sck_rises - b_sck, 4);
        check("dr_hi_len", last_hi, 4);

        // Dual write, div=0, 0x96: IO1 carries bit7, IO0 bit6.
        b_busy = busy_cyc;
        launch(1'b1, 1'b1, 8'h96, 8'd0, 1'b0, 1'b0);
        check("dw_oe", {IO1_OE, IO0_OE}, 2'b11);
        check("dw_first_bits", {IO1_O, IO0_O}, 2'b10);
        wait_done(100, ok);
        check("dw_done_seen", ok, 1'b1);
        check("dw_oe_idle", {IO1_OE, IO0_OE}, 2'b00);
        step();
        check("dw_busy_cyc", busy_cyc - b_busy, 9);

        // Held chip-select 1 across two bytes, then release.
        loopback = 1'b1;
        launch(1'b0, 1'b0, 8'h9F, 8'd0, 1'b1, 1'b1);
        b_ss0 = ss0_low; b_ss1 = ss1_high;
        wait_done(100, ok);
        check("h1_done_seen", ok, 1'b1);
        check("h1_rd", rd_data, 8'h9F);
        repeat (2) step();
        launch(1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b1);
        check("h2_ss_reused", SPI_SS, 2'b01);
        wait_done(100, ok);
        check("h2_done_seen", ok, 1'b1);
        check("h2_rd", rd_data, 8'h00);
        repeat (2) step();
        check("h_ss_still_low", SPI_SS, 2'b01);
        check("h_ss1_never_high", ss1_high - b_ss1, 0);
        check("h_ss0_never_low", ss0_low - b_ss0, 0);
        cs_release = 1'b1;
        step();
        cs_release = 1'b0;
        check("h_release", SPI_SS, 2'b11);

        // start during a busy transfer is ignored.
        b_busy = busy_cyc; b_done = done_cnt;
        launch(1'b0, 1'b0, 8'h3C, 8'd0, 1'b0, 1'b0);
        repeat (3) step();
        wr_data = 8'hFF;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(100, ok);
        check("ig_done_seen", ok, 1'b1);
        check("ig_rd", rd_data, 8'h3C);
        repeat (20) step();
        check("ig_busy_cyc", busy_cyc - b_busy, 17);
        check("ig_done_cnt", done_cnt - b_done, 1);
        check("ig_idle", busy, 1'b0);

        // Reset asserted during the 4th SCK high phase.
        b_done = done_cnt;
        launch(1'b0, 1'b0, 8'hFF, 8'd1, 1'b0, 1'b0);
        rises = 0; prev = SPI_SCK;
        for (int i = 0; i < 100 && rises < 4; i++) begin
            step();
            if (SPI_SCK && !prev) rises++;
            prev = SPI_SCK;
        end
        check("ab_reached_4th", rises, 4);
        RST_N = 1'b0;
        #1;
        check("ab_sck", SPI_SCK, 1'b0);
        check("ab_ss", SPI_SS, 2'b11);
        check("ab_oe", {IO1_OE, IO0_OE}, 2'b00);
        check("ab_busy", busy, 1'b0);
        repeat (2) @(negedge CLK1);
        RST_N = 1'b1;
        repeat (5) step();
        check("ab_no_done", done_cnt - b_done, 0);
        b_busy = busy_cyc;
        launch(1'b0, 1'b0, 8'h55, 8'd0, 1'b0, 1'b0);
        wait_done(100, ok);
        check("ab_done_seen", ok, 1'b1);
        check("ab_rd55", rd_data, 8'h55);
        step();
        check("ab_busy_cyc", busy_cyc - b_busy, 17);

        // div change mid-byte only affects the next byte.
        b_busy = busy_cyc;
        launch(1'b0, 1'b0, 8'h5A, 8'd0, 1'b0, 1'b0);
        repeat (3) step();
        div = 8'd7;
        wait_done(100, ok);
        check("dv_done_seen", ok, 1'b1);
        check("dv_rd", rd_data, 8'h5A);
        step();
        check("dv_busy_cyc", busy_cyc - b_busy, 17);
        b_busy = busy_cyc;
        launch(1'b0, 1'b0, 8'hC3, 8'd7, 1'b0, 1'b0);
        wait_done(400, ok);
        check("dv2_done_seen", ok, 1'b1);
        check("dv2_rd", rd_data, 8'hC3);
        step();
        check("dv2_busy_cyc", busy_cyc - b_busy, 136);
        check("dv2_hi_len", last_hi, 8);

        check("ss_one_low_max", multi_low, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
